// File: rtl/ucode_loader.sv
// ucode_loader
// ------------
// Boot-time loader for the 128 x 64-bit microcode control store, plus the
// hold/restart control for the microsequencer.
//
// A 32-bit valid/ready stream supplies, for every store entry, a low word
// followed by a high word. Each pair is written to the store one cycle after
// the high word is accepted. One trailing checksum word is then compared with
// the running XOR of every data word. A match releases the microsequencer
// with a single-cycle restart pulse. A mismatch parks the loader in an error
// state with the sequencer still held.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high reset
//   start        : one-cycle request to (re)load the store (ignored while busy)
//   in_valid     : stream word valid
//   in_data      : stream word (lo, hi, ..., checksum)
//   in_ready     : loader accepts in_data this cycle (decoded from state only)
//   cs_we        : control-store write enable (one cycle per entry)
//   cs_waddr     : control-store write address
//   cs_wdata     : control-store write data {hi, lo}
//   seq_hold     : microsequencer must not advance while high
//   seq_restart  : one-cycle pulse forcing the sequencer address to 0
//   busy         : load in progress
//   done         : store loaded and checksum verified
//   err          : checksum mismatch on the last load

module ucode_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int WORD_W = 64,
    parameter int IN_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_ready,
    output logic              cs_we,
    output logic [ADDR_W-1:0] cs_waddr,
    output logic [WORD_W-1:0] cs_wdata,
    output logic              seq_hold,
    output logic              seq_restart,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra counter bit so the entry count can never alias back to 0
    // within a load.
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        CHECK,
        RUN,
        ERR
    } state_t;

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [IN_W-1:0]   acc_q,         acc_d;
    logic [IN_W-1:0]   lo_q,          lo_d;
    logic              cs_we_q,       cs_we_d;
    logic [ADDR_W-1:0] cs_waddr_q,    cs_waddr_d;
    logic [WORD_W-1:0] cs_wdata_q,    cs_wdata_d;
    logic              seq_hold_q,    seq_hold_d;
    logic              seq_restart_q, seq_restart_d;
    logic              busy_q,        busy_d;
    logic              done_q,        done_d;
    logic              err_q,         err_d;
    logic              in_ready_q,    in_ready_d;
    logic              xfer;

    // in_ready_q is registered from the next state, so it is exactly a
    // function of the current state.
    assign xfer = in_valid & in_ready_q;

    // Next-state and datapath updates. Nothing changes unless a word is
    // actually transferred, so input stalls are side-effect free.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        cs_we_d    = 1'b0;
        cs_waddr_d = cs_waddr_q;
        cs_wdata_d = cs_wdata_q;

        case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d = LO;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            LO: begin
                if (xfer) begin
                    lo_d    = in_data;
                    acc_d   = acc_q ^ in_data;
                    state_d = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    acc_d      = acc_q ^ in_data;
                    cs_we_d    = 1'b1;
                    cs_waddr_d = cnt_q[ADDR_W-1:0];
                    cs_wdata_d = {in_data, lo_q};
                    cnt_d      = cnt_q + CNT_W'(1);
                    state_d    = (cnt_q == LAST) ? CHECK : LO;
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_d = (in_data == acc_q) ? RUN : ERR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state and registered, so they
    // are glitch-free and only move on state transitions. The restart pulse
    // marks the single cycle in which RUN is first entered.
    always_comb begin
        seq_hold_d    = (state_d != RUN);
        done_d        = (state_d == RUN);
        err_d         = (state_d == ERR);
        busy_d        = (state_d == LO) || (state_d == HI) || (state_d == CHECK);
        in_ready_d    = busy_d;
        seq_restart_d = (state_d == RUN) && (state_q != RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            lo_q          <= '0;
            cs_we_q       <= 1'b0;
            cs_waddr_q    <= '0;
            cs_wdata_q    <= '0;
            seq_hold_q    <= 1'b1;
            seq_restart_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            lo_q          <= lo_d;
            cs_we_q       <= cs_we_d;
            cs_waddr_q    <= cs_waddr_d;
            cs_wdata_q    <= cs_wdata_d;
            seq_hold_q    <= seq_hold_d;
            seq_restart_q <= seq_restart_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign cs_we       = cs_we_q;
    assign cs_waddr    = cs_waddr_q;
    assign cs_wdata    = cs_wdata_q;
    assign seq_hold    = seq_hold_q;
    assign seq_restart = seq_restart_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ucode_loader.sv
// tb_ucode_loader
// ---------------
// Directed bench for ucode_loader. Expected control-store writes are queued
// as each high word is accepted and compared when cs_we appears; status
// outputs are checked after each load.

module tb_ucode_loader;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int WORD_W = 64;
    localparam int IN_W   = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              in_ready;
    logic              cs_we;
    logic [ADDR_W-1:0] cs_waddr;
    logic [WORD_W-1:0] cs_wdata;
    logic              seq_hold;
    logic              seq_restart;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    wr_t sbQ[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  restartCount = 0;
    int  restartCyc = -1;
    int  firstEdge = -1;
    int  chkEdge = -1;

    ucode_loader #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W),
        .IN_W  (IN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cs_we      (cs_we),
        .cs_waddr   (cs_waddr),
        .cs_wdata   (cs_wdata),
        .seq_hold   (seq_hold),
        .seq_restart(seq_restart),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge index, readable #1 after an edge or at the following
    // falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every cs_we must match the oldest queued write, and a
    // write with nothing queued is an extra pulse.
    always @(negedge clk) begin
        if (seq_restart) begin
            restartCount++;
            restartCyc = cyc;
        end
        if (cs_we) begin
            tests++;
            assert (sbQ.size() != 0) else begin
                fails++;
                $error("[TB] FAIL extra_write: observed addr %0h data %0h, expected no write",
                       cs_waddr, cs_wdata);
            end
            if (sbQ.size() != 0) begin
                wr_t e;
                e = sbQ.pop_front();
                tests++;
                assert ({cs_waddr, cs_wdata} === {e.addr, e.data}) else begin
                    fails++;
                    $error("[TB] FAIL write: observed addr %0h data %0h, expected addr %0h data %0h",
                           cs_waddr, cs_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one word after 'gap' idle cycles, optionally with start raised
    // in the same cycle; returns once the word has been accepted.
    task automatic sendWord(input logic [IN_W-1:0] w, input int gap,
                            input logic withStart, output logic ok);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        start    = withStart;
        ok       = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checkOutput("handshake_timeout", 64'd0, 64'd1);
        end
    endtask

    // Full load: entry i is lo=i, hi=~i. stallMode inserts random gaps and a
    // 10-cycle gap inside entry 5; startAt pulses start alongside that
    // entry's high word; abortAt resets once that entry's write has landed.
    task automatic applyStimulus(input bit stallMode, input bit badSum,
                                 input int startAt, input int abortAt);
        logic [IN_W-1:0] acc;
        logic [IN_W-1:0] lo;
        logic [IN_W-1:0] hi;
        logic            ok;
        wr_t             e;
        restartCount = 0;
        restartCyc   = -1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        checkOutput("ready_after_start", 64'(in_ready), 64'd1);
        checkOutput("hold_after_start", 64'(seq_hold), 64'd1);
        acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lo = IN_W'(i);
            hi = ~lo;
            sendWord(lo, stallMode ? int'($urandom_range(0, 3)) : 0, 1'b0, ok);
            if (i == 0) firstEdge = cyc;
            acc ^= lo;
            sendWord(hi, stallMode ? ((i == 5) ? 10 : int'($urandom_range(0, 3))) : 0,
                     (i == startAt), ok);
            if (ok) begin
                e.addr = ADDR_W'(i);
                e.data = {hi, lo};
                sbQ.push_back(e);
            end
            acc ^= hi;
            if (i == abortAt) begin
                @(negedge clk);
                #1;
                reset = 1'b1;
                #1;
                checkOutput("abort_busy", 64'(busy), 64'd0);
                checkOutput("abort_done", 64'(done), 64'd0);
                checkOutput("abort_err", 64'(err), 64'd0);
                checkOutput("abort_hold", 64'(seq_hold), 64'd1);
                checkOutput("abort_queue_empty", 64'(sbQ.size()), 64'd0);
                @(posedge clk);
                #2;
                reset = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        sendWord(badSum ? (acc ^ 32'd1) : acc, stallMode ? 2 : 0, 1'b0, ok);
        chkEdge = cyc;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic verifyLoad(input string tag, input bit good, input bit noStall);
        checkOutput({tag, "_done"}, 64'(done), good ? 64'd1 : 64'd0);
        checkOutput({tag, "_err"}, 64'(err), good ? 64'd0 : 64'd1);
        checkOutput({tag, "_hold"}, 64'(seq_hold), good ? 64'd0 : 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_restarts"}, 64'(restartCount), good ? 64'd1 : 64'd0);
        checkOutput({tag, "_writes_left"}, 64'(sbQ.size()), 64'd0);
        if (good) begin
            checkOutput({tag, "_restart_after_check"}, 64'(restartCyc), 64'(chkEdge));
            if (noStall) begin
                checkOutput({tag, "_restart_latency"}, 64'(restartCyc - firstEdge),
                            64'(2 * DEPTH));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #3;
        checkOutput("rst_hold", 64'(seq_hold), 64'd1);
        checkOutput("rst_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_we", 64'(cs_we), 64'd0);
        checkOutput("rst_restart", 64'(seq_restart), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_waddr", 64'(cs_waddr), 64'd0);
        checkOutput("rst_wdata", cs_wdata, 64'd0);
        #9;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_hold", 64'(seq_hold), 64'd1);
        checkOutput("idle_ready", 64'(in_ready), 64'd0);

        applyStimulus(1'b0, 1'b0, -1, -1);
        verifyLoad("good1", 1'b1, 1'b1);

        applyStimulus(1'b0, 1'b1, -1, -1);
        verifyLoad("badsum", 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, -1, -1);
        verifyLoad("recover", 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b0, -1, -1);
        verifyLoad("stall", 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b0, 40, -1);
        verifyLoad("start_in_hi", 1'b1, 1'b1);

        applyStimulus(1'b0, 1'b0, -1, 60);
        checkOutput("post_abort_busy", 64'(busy), 64'd0);
        checkOutput("post_abort_hold", 64'(seq_hold), 64'd1);

        applyStimulus(1'b0, 1'b0, -1, -1);
        verifyLoad("fresh", 1'b1, 1'b1);

        // Asynchronous reset in the middle of a RUN cycle.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_hold", 64'(seq_hold), 64'd1);
        checkOutput("async_rst_done", 64'(done), 64'd0);
        checkOutput("async_rst_err", 64'(err), 64'd0);
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        #3;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("async_rst_idle_busy", 64'(busy), 64'd0);
        checkOutput("async_rst_idle_hold", 64'(seq_hold), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
